muldiv_seq: RTL and testbench

- Multi-cycle integer multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Takes the M-extension operations off the single-cycle path (MUL variants are not implemented in the ALU; its DIV/REM is too slow for timing).
- Uses the same 5-bit operator codes from the shared define file (ALU_OPERATOR_MUL/MULH/MULU/MULHU/DIV/DIVU/REM/REMU).
- Request/response valid-ready handshake; the pipeline stalls while a request is outstanding.

---
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle M-extension multiply/divide unit for the execute stage.
// Multiplication is shift-add and division is restoring shift-subtract. Both run
// on operand magnitudes and produce one bit per cycle; the result sign is
// restored when the final result is registered.
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake; ready only while idle
//   operator           ALU_OPERATOR_* code, sampled on accept
//   operand1/2         rs1/dividend and rs2/divisor, sampled on accept
//   flush              abort the current operation and return to idle
//   resp_valid/ready   response handshake
//   result             result, held stable while resp_valid
//   result_is_zero     registered with result (ALU_RESULT_IS_ZERO when result==0)
//   resp_illegal       operator was not a supported multiply/divide code
module muldiv_seq #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      operator,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            result_is_zero,
  output logic            resp_illegal
);

  localparam logic [4:0] ALU_OPERATOR_MUL   = 5'h10;
  localparam logic [4:0] ALU_OPERATOR_MULH  = 5'h11;
  localparam logic [4:0] ALU_OPERATOR_MULU  = 5'h12;
  localparam logic [4:0] ALU_OPERATOR_MULHU = 5'h13;
  localparam logic [4:0] ALU_OPERATOR_DIV   = 5'h14;
  localparam logic [4:0] ALU_OPERATOR_DIVU  = 5'h15;
  localparam logic [4:0] ALU_OPERATOR_REM   = 5'h16;
  localparam logic [4:0] ALU_OPERATOR_REMU  = 5'h17;

  localparam logic ALU_RESULT_IS_ZERO     = 1'b1;
  localparam logic ALU_RESULT_IS_NOT_ZERO = 1'b0;

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic            accept, last;
  logic [CW-1:0]   count;
  logic            op_mul, op_high, op_rem, res_neg, dz, special;
  logic [XLEN-1:0] hi, lo, mcand, hi_n, lo_n;

  // request decode
  logic            legal, d_mul, d_high, d_rem, d_sgn, a_neg, b_neg, d_dz, d_ovf, d_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  // datapath
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready && !flush;

  always_comb begin
    legal  = 1'b1;
    d_mul  = 1'b0;
    d_high = 1'b0;
    d_rem  = 1'b0;
    d_sgn  = 1'b0;
    case (operator)
      ALU_OPERATOR_MUL:   d_mul = 1'b1;
      ALU_OPERATOR_MULH:  begin d_mul = 1'b1; d_high = 1'b1; d_sgn = 1'b1; end
      ALU_OPERATOR_MULU:  d_mul = 1'b1;
      ALU_OPERATOR_MULHU: begin d_mul = 1'b1; d_high = 1'b1; end
      ALU_OPERATOR_DIV:   d_sgn = 1'b1;
      ALU_OPERATOR_DIVU:  legal = 1'b1;
      ALU_OPERATOR_REM:   begin d_rem = 1'b1; d_sgn = 1'b1; end
      ALU_OPERATOR_REMU:  d_rem = 1'b1;
      default:            legal = 1'b0;
    endcase
    a_neg = d_sgn && operand1[XLEN-1];
    b_neg = d_sgn && operand2[XLEN-1];
    a_abs = a_neg ? -operand1 : operand1;
    b_abs = b_neg ? -operand2 : operand2;
    d_dz  = !d_mul && (operand2 == '0);
    d_ovf = !d_mul && d_sgn && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
    // A zero divisor yields an all-ones quotient, so the quotient sign is never applied there.
    if (d_mul)      d_neg = a_neg ^ b_neg;
    else if (d_rem) d_neg = a_neg;
    else            d_neg = (a_neg ^ b_neg) && !d_dz;
  end

  // One iteration step; hi:lo is the product/shift register, mcand the multiplicand or divisor.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, mcand};
    if (op_mul) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end else begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end
  end

  // Final result from the last step; special cases are resolved from the latched dividend.
  always_comb begin
    prod = {hi_n, lo_n};
    quo  = special ? (dz ? '1 : lo) : lo_n;
    rem  = special ? (dz ? lo : '0) : hi_n;
    if (res_neg) begin
      prod = -prod;
      quo  = -quo;
      rem  = -rem;
    end
    if (op_mul) fin = op_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else        fin = op_rem ? rem : quo;
  end

  assign last = (state == CALC) && (special || (count == CW'(XLEN-1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = legal ? CALC : DONE;
      CALC:    if (last) state_n = DONE;
      DONE:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count          <= '0;
      op_mul         <= 1'b0;
      op_high        <= 1'b0;
      op_rem         <= 1'b0;
      res_neg        <= 1'b0;
      dz             <= 1'b0;
      special        <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      mcand          <= '0;
      result         <= '0;
      result_is_zero <= ALU_RESULT_IS_ZERO;
      resp_illegal   <= 1'b0;
    end else if (accept) begin
      count        <= '0;
      op_mul       <= d_mul;
      op_high      <= d_high;
      op_rem       <= d_rem;
      res_neg      <= d_neg;
      dz           <= d_dz;
      special      <= FAST_SPECIAL && (d_dz || d_ovf);
      hi           <= '0;
      lo           <= d_mul ? b_abs : a_abs;
      mcand        <= d_mul ? a_abs : b_abs;
      resp_illegal <= !legal;
      if (!legal) begin
        result         <= '0;
        result_is_zero <= ALU_RESULT_IS_ZERO;
      end
    end else if (state == CALC && !flush) begin
      hi    <= hi_n;
      lo    <= lo_n;
      count <= count + CW'(1);
      if (last) begin
        result         <= fin;
        result_is_zero <= (fin == '0) ? ALU_RESULT_IS_ZERO : ALU_RESULT_IS_NOT_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed self-checking bench for muldiv_seq.
// Two instances (FAST_SPECIAL=1 and 0) receive identical stimulus; each result
// is compared against a 64-bit arithmetic reference model.
module tb_muldiv_seq;

  localparam logic [4:0] OP_MUL   = 5'h10;
  localparam logic [4:0] OP_MULH  = 5'h11;
  localparam logic [4:0] OP_MULU  = 5'h12;
  localparam logic [4:0] OP_MULHU = 5'h13;
  localparam logic [4:0] OP_DIV   = 5'h14;
  localparam logic [4:0] OP_DIVU  = 5'h15;
  localparam logic [4:0] OP_REM   = 5'h16;
  localparam logic [4:0] OP_REMU  = 5'h17;

  logic        clk = 1'b0;
  logic        rstn, req_valid, flush, resp_ready;
  logic [4:0]  operator;
  logic [31:0] operand1, operand2;

  logic        req_ready_f, resp_valid_f, zero_f, ill_f;
  logic        req_ready_s, resp_valid_s, zero_s, ill_s;
  logic [31:0] result_f, result_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_f),
    .operator(operator), .operand1(operand1), .operand2(operand2), .flush(flush),
    .resp_valid(resp_valid_f), .resp_ready(resp_ready), .result(result_f),
    .result_is_zero(zero_f), .resp_illegal(ill_f)
  );

  muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_s),
    .operator(operator), .operand1(operand1), .operand2(operand2), .flush(flush),
    .resp_valid(resp_valid_s), .resp_ready(resp_ready), .result(result_s),
    .result_is_zero(zero_s), .resp_illegal(ill_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [4:0] op);
    return op >= OP_MUL && op <= OP_REMU;
  endfunction

  function automatic logic is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) begin
      if (b == 32'h0) return 1'b1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq;
    logic [63:0] up, sp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'h0, a} * {32'h0, b};
    sp = sa * sb;
    case (op)
      OP_MUL, OP_MULU: return up[31:0];
      OP_MULH:         return sp[63:32];
      OP_MULHU:        return up[63:32];
      OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        sq = sa / sb;
        return sq[31:0];
      end
      OP_REM: begin
        if (b == 32'h0) return a;
        sq = sa % sb;
        return sq[31:0];
      end
      OP_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 32'h0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    operator  = op;
    operand1  = a;
    operand2  = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Cycles from the accept edge until each instance raises resp_valid (-1 if never).
  task automatic wait_valid(output int lf, output int ls);
    lf = -1;
    ls = -1;
    for (int c = 0; c < 40; c++) begin
      if (lf < 0 && resp_valid_f) lf = c;
      if (ls < 0 && resp_valid_s) ls = c;
      if (lf >= 0 && ls >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lf, ls, exp_lf, exp_ls;
    logic [31:0] exp;
    logic        ill;
    ill    = !is_legal(op);
    exp    = ill ? 32'h0 : ref_result(op, a, b);
    exp_ls = ill ? 0 : 32;
    exp_lf = ill ? 0 : (is_special(op, a, b) ? 1 : 32);
    wait_valid(lf, ls);
    check({tag, "/lat_fast"}, 64'(lf), 64'(exp_lf));
    check({tag, "/lat_slow"}, 64'(ls), 64'(exp_ls));
    check({tag, "/res_fast"}, 64'(result_f), 64'(exp));
    check({tag, "/res_slow"}, 64'(result_s), 64'(exp));
    check({tag, "/zero_fast"}, 64'(zero_f), 64'(exp == 32'h0));
    check({tag, "/zero_slow"}, 64'(zero_s), 64'(exp == 32'h0));
    check({tag, "/ill_fast"}, 64'(ill_f), 64'(ill));
    check({tag, "/ill_slow"}, 64'(ill_s), 64'(ill));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "/consumed"}, {60'h0, resp_valid_f, resp_valid_s, req_ready_f, req_ready_s}, 64'h3);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    finish_op(tag, op, a, b);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  localparam int ND = 16;
  logic [4:0]  d_op [ND] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULU, OP_DIV, OP_REM, OP_DIVU, OP_REMU,
                             OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REMU, OP_MUL, 5'h1F};
  logic [31:0] d_a  [ND] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                             32'h8000_0000, 32'hFFFF_FFFB, 32'd9, 32'd0, 32'd3};
  logic [31:0] d_b  [ND] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                             32'd0, 32'd1234, 32'd4};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lf, ls, seen;
    logic [4:0]  op;
    logic [31:0] a, b, held;

    rstn = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    operator = 5'h0; operand1 = 32'h0; operand2 = 32'h0;
    repeat (2) @(negedge clk);
    check("reset/result", {result_f, result_s}, 64'h0);
    check("reset/flags", {58'h0, zero_f, zero_s, req_ready_f, req_ready_s, resp_valid_f, resp_valid_s}, 64'h3C);
    check("reset/illegal", {62'h0, ill_f, ill_s}, 64'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < ND; i++) run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);

    for (int i = 0; i < 40; i++) begin
      op = 5'(OP_MUL + 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 15));
      a = rand_operand();
      b = rand_operand();
      run_op($sformatf("rnd%0d", i), op, a, b);
    end

    // Backpressure: response held, second request ignored, next request one cycle after consume.
    issue(OP_MULU, 32'd12345, 32'd678);
    wait_valid(lf, ls);
    check("bp/valid", {62'h0, resp_valid_f, resp_valid_s}, 64'h3);
    held = 32'd12345 * 32'd678;
    operator = OP_DIVU; operand1 = 32'd50; operand2 = 32'd5; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp/result", {result_f, result_s}, {held, held});
      check("bp/hs", {60'h0, resp_valid_f, resp_valid_s, req_ready_f, req_ready_s}, 64'hC);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp/idle", {60'h0, resp_valid_f, resp_valid_s, req_ready_f, req_ready_s}, 64'h3);
    issue(OP_DIVU, 32'd50, 32'd5);
    check("bp/accepted", {62'h0, req_ready_f, req_ready_s}, 64'h0);
    finish_op("bp/next", OP_DIVU, 32'd50, 32'd5);

    // Flush at CALC cycle 10, then a request presented together with flush.
    issue(OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/idle", {60'h0, resp_valid_f, resp_valid_s, req_ready_f, req_ready_s}, 64'h3);
    flush = 1'b1;
    operator = OP_MUL; operand1 = 32'd2; operand2 = 32'd2; req_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush/no_accept", {62'h0, req_ready_f, req_ready_s}, 64'h3);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_f || resp_valid_s) seen++;
      @(negedge clk);
    end
    check("flush/no_resp", 64'(seen), 64'h0);

    // Reset pulse at cycle 20 of an operation.
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst/result", {result_f, result_s}, 64'h0);
    check("rst/flags", {58'h0, zero_f, zero_s, req_ready_f, req_ready_s, resp_valid_f, resp_valid_s}, 64'h3C);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst/idle", {60'h0, resp_valid_f, resp_valid_s, req_ready_f, req_ready_s}, 64'h3);
    run_op("rst/mul3x4", OP_MUL, 32'd3, 32'd4);
    run_op("illegal", 5'h1F, 32'h55, 32'hAA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
